// File: rtl/sseg_scan_ctrl.sv
// Scan controller sharing one BCD-to-seven-segment decoder across N_DIGITS
// common-anode digits. Frame data is double-buffered and committed only at frame boundaries.
module sseg_scan_ctrl #(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [4*N_DIGITS-1:0] wr_digits,
  input  logic [N_DIGITS-1:0]   wr_dp,
  input  logic                  blank,
  output logic [3:0]            bcd_digit,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   anode,
  output logic                  frame_tick
);

  localparam int               IDX_W    = $clog2(N_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic                  tick;
  logic                  boundary;
  logic                  wr_fire;
  logic [N_DIGITS-1:0]   sel_onehot;

  logic [4*N_DIGITS-1:0] active_digits;
  logic [N_DIGITS-1:0]   active_dp;
  logic [4*N_DIGITS-1:0] pend_digits;
  logic [N_DIGITS-1:0]   pend_dp;
  logic                  pend_valid;

  assign tick       = (cnt == CNT_LAST);
  assign boundary   = tick && (idx == IDX_LAST);
  assign wr_ready   = ~pend_valid;
  assign wr_fire    = wr_valid && wr_ready;
  assign sel_onehot = N_DIGITS'(1) << idx;

  // Refresh divider and scan index.
  // NOTE: every register here uses <=, so all processes sample the pre-edge idx and cnt.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
    end
  end

  // A write and a commit can never coincide on a full buffer because wr_ready is low then;
  // a write landing on a boundary with an empty buffer waits for the next boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      active_digits <= '0;
      active_dp     <= '0;
      pend_valid    <= 1'b0;
    end else if (boundary && pend_valid) begin
      active_digits <= pend_digits;
      active_dp     <= pend_dp;
      pend_valid    <= 1'b0;
    end else if (wr_fire) begin
      pend_valid    <= 1'b1;
    end
  end

  // NOTE: the pending payload is not reset; it is only ever consumed behind pend_valid.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      pend_digits <= wr_digits;
      pend_dp     <= wr_dp;
    end
  end

  // Registered decoder and anode drive, one cycle behind idx.
  always_ff @(posedge clk) begin
    if (reset) begin
      anode      <= '1;
      bcd_digit  <= '0;
      dp         <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      anode      <= blank ? '1 : ~sel_onehot;
      bcd_digit  <= active_digits[{idx, 2'b00} +: 4];
      dp         <= active_dp[idx];
      frame_tick <= boundary;
    end
  end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Scoreboard bench for sseg_scan_ctrl (N_DIGITS=4, REFRESH_DIV=4): stimulus queues the
// expected frame contents, a monitor pops one record per displayed frame and checks every slot.
module tb_sseg_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_digits;
  logic [3:0]  wr_dp;
  logic        blank;
  logic [3:0]  bcd_digit;
  logic        dp;
  logic [3:0]  anode;
  logic        frame_tick;

  typedef struct {
    logic [15:0] digits;
    logic [3:0]  dps;
    logic        blanked;
  } frame_t;

  frame_t sb_q[$];
  frame_t cur;
  int     n_tests = 0;
  int     n_fail  = 0;
  int     cyc     = 0;
  int     slot;
  logic   ft_prev = 1'b0;
  logic [3:0] exp_an;

  sseg_scan_ctrl #(.N_DIGITS(4), .REFRESH_DIV(4), .CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_digits  (wr_digits),
    .wr_dp      (wr_dp),
    .blank      (blank),
    .bcd_digit  (bcd_digit),
    .dp         (dp),
    .anode      (anode),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  // Cycles since the last reset edge; 1 on the first edge with reset low.
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [15:0] d, input logic [3:0] p, input logic b);
    frame_t f;
    f.digits  = d;
    f.dps     = p;
    f.blanked = b;
    sb_q.push_back(f);
  endtask

  // Returns 2 time units after the edge that makes cyc == n.
  task automatic goto(input int n);
    int guard;
    guard = 0;
    do begin
      @(posedge clk);
      #1;
      guard++;
    end while (cyc != n && guard < 2000);
    if (cyc != n) begin
      $display("FAIL goto: cyc %0d expected %0d", cyc, n);
      $fatal(1, "cycle alignment lost");
    end
    #1;
  endtask

  task automatic check_reset_vals();
    check("rst_anode", anode, 4'hF);
    check("rst_bcd", bcd_digit, 4'h0);
    check("rst_dp", dp, 1'b0);
    check("rst_frame_tick", frame_tick, 1'b0);
    check("rst_wr_ready", wr_ready, 1'b1);
  endtask

  // Monitor: one record per displayed frame, popped on the first cycle after reset
  // and on the cycle after each frame_tick.
  always @(negedge clk) begin
    if (cyc == 0) begin
      ft_prev = 1'b0;
    end else begin
      if (cyc == 1 || ft_prev) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_pop: got empty queue expected a frame record (cyc %0d)", cyc);
        end else begin
          cur = sb_q.pop_front();
        end
      end
      slot   = ((cyc - 1) % 16) / 4;
      exp_an = cur.blanked ? 4'hF : ~(4'b0001 << slot);
      check("anode", anode, exp_an);
      check("bcd_digit", bcd_digit, cur.digits[4*slot +: 4]);
      check("dp", dp, cur.dps[slot]);
      check("frame_tick", frame_tick, (cyc % 16) == 0);
      ft_prev = frame_tick;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset     = 1'b1;
    wr_valid  = 1'b0;
    wr_digits = 16'h0000;
    wr_dp     = 4'b0000;
    blank     = 1'b0;
    push(16'h0000, 4'b0000, 1'b0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals();

    // Release reset and offer the first frame at once.
    @(posedge clk);
    #2;
    reset     = 1'b0;
    wr_valid  = 1'b1;
    wr_digits = 16'h4321;
    wr_dp     = 4'b0010;
    push(16'h4321, 4'b0010, 1'b0);

    // Accepted on edge 1; a second frame is held offered while pending is full.
    goto(1);
    wr_digits = 16'h8765;
    wr_dp     = 4'b0101;
    push(16'h8765, 4'b0101, 1'b0);
    @(negedge clk);
    check("first_anode", anode, 4'hE);
    check("ready_after_wr", wr_ready, 1'b0);

    goto(15);
    @(negedge clk);
    check("ready_full", wr_ready, 1'b0);
    goto(16);
    @(negedge clk);
    check("commit_tick", frame_tick, 1'b1);
    check("ready_after_commit", wr_ready, 1'b1);

    goto(17);
    wr_valid = 1'b0;
    @(negedge clk);
    check("second_accepted", wr_ready, 1'b0);

    // Write landing on the boundary edge 48 while pending is empty.
    goto(47);
    wr_valid  = 1'b1;
    wr_digits = 16'hFA90;
    wr_dp     = 4'b1000;
    push(16'h8765, 4'b0101, 1'b0);
    push(16'hFA90, 4'b1000, 1'b0);
    @(negedge clk);
    check("ready_empty_47", wr_ready, 1'b1);
    goto(48);
    wr_valid = 1'b0;
    @(negedge clk);
    check("ready_boundary_wr", wr_ready, 1'b0);
    goto(63);
    @(negedge clk);
    check("ready_held_63", wr_ready, 1'b0);
    goto(64);
    @(negedge clk);
    check("ready_commit_64", wr_ready, 1'b1);

    // Two blanked frames; a commit still happens during the blanking.
    goto(80);
    blank = 1'b1;
    push(16'hFA90, 4'b1000, 1'b1);
    goto(84);
    wr_valid  = 1'b1;
    wr_digits = 16'h1357;
    wr_dp     = 4'b0001;
    push(16'h1357, 4'b0001, 1'b1);
    push(16'h1357, 4'b0001, 1'b0);
    goto(85);
    wr_valid = 1'b0;
    goto(112);
    blank = 1'b0;

    // Fill pending, then reset mid-frame: nothing may survive.
    goto(114);
    wr_valid  = 1'b1;
    wr_digits = 16'h9999;
    wr_dp     = 4'b1111;
    goto(115);
    wr_valid = 1'b0;
    @(negedge clk);
    check("ready_full_115", wr_ready, 1'b0);
    goto(119);
    reset = 1'b1;
    @(posedge clk);
    #1;
    sb_q.delete();
    push(16'h0000, 4'b0000, 1'b0);
    push(16'h0000, 4'b0000, 1'b0);
    @(negedge clk);
    check_reset_vals();
    @(posedge clk);
    #2;
    reset = 1'b0;

    goto(1);
    @(negedge clk);
    check("post_rst_anode", anode, 4'hE);
    check("post_rst_bcd", bcd_digit, 4'h0);

    goto(32);
    @(negedge clk);
    #1;
    check("sb_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
